shared_net_arbiter: RTL and testbench

Sequences ownership of a single shared, weakly-pulled-down net among N requesting drivers. At most one requester holds drive enable at any time. Ownership changes always pass through a turnaround window in which every strong driver is released and only the weak pulldown defines the net, so the resolved value is well-defined `0` rather than `x`. The block sits beside the net's driver/pull cells and owns their enables: one `grant` bit per buffer and `pull_en` for the pulldown.

---
 rtl/shared_net_pkg.sv | 15 +
 rtl/rr_pick.sv | 29 ++
 rtl/shared_net_arbiter.sv | 124 ++++++++++++
 tb/tb_shared_net_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/shared_net_pkg.sv
// Shared types and width helpers for the shared-net ownership arbiter.
package shared_net_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StTurn
    } arb_state_e;

    // $clog2 clamped to at least one bit so zero-width counters never appear.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after ptr, wrapping.
module rr_pick
    import shared_net_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [W-1:0]     ptr,
    output logic [W-1:0]     idx,
    output logic             found
);

    int unsigned j;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/shared_net_arbiter.sv
// Sequences ownership of a weakly-pulled-down shared net, inserting a released-net
// turnaround window between every pair of owners.
module shared_net_arbiter
    import shared_net_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned MAX_HOLD    = 16,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req,
    output logic [N_REQ-1:0]              grant,
    output logic [clog2_min1(N_REQ)-1:0]  owner,
    output logic                          busy,
    output logic                          pull_en,
    output logic                          timeout
);

    localparam int unsigned OW = clog2_min1(N_REQ);
    localparam int unsigned HW = clog2_min1(MAX_HOLD + 1);
    localparam int unsigned TW = clog2_min1(TURN_CYCLES + 1);
    localparam logic [HW-1:0] HoldMax = HW'(MAX_HOLD);

    arb_state_e        state_q;
    logic [N_REQ-1:0]  grant_q;
    logic [OW-1:0]     owner_q;
    logic              busy_q;
    logic              pull_en_q;
    logic              timeout_q;
    logic [OW-1:0]     ptr_q;
    logic [HW-1:0]     hold_q;
    logic [TW-1:0]     turn_q;

    logic [OW-1:0]     pick;
    logic              pick_found;
    logic [N_REQ-1:0]  pick_onehot;
    logic              owner_req;
    logic [OW-1:0]     next_ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .W     (OW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick),
        .found (pick_found)
    );

    always_comb begin
        pick_onehot       = '0;
        pick_onehot[pick] = 1'b1;
    end

    assign owner_req = req[owner_q];
    assign next_ptr  = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            pull_en_q <= 1'b1;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
            turn_q    <= '0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        state_q   <= StGrant;
                        grant_q   <= pick_onehot;
                        owner_q   <= pick;
                        busy_q    <= 1'b1;
                        pull_en_q <= 1'b0;
                        hold_q    <= HW'(1);
                    end
                end
                StGrant: begin
                    // Release is checked first so a drop on the expiry edge is no timeout.
                    if (!owner_req || (MAX_HOLD != 0 && hold_q == HoldMax)) begin
                        state_q   <= StTurn;
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        pull_en_q <= 1'b1;
                        timeout_q <= owner_req;
                        ptr_q     <= next_ptr;
                        turn_q    <= TW'(TURN_CYCLES);
                    end else if (hold_q != '1) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                StTurn: begin
                    if (turn_q == TW'(1)) begin
                        if (pick_found) begin
                            state_q   <= StGrant;
                            grant_q   <= pick_onehot;
                            owner_q   <= pick;
                            busy_q    <= 1'b1;
                            pull_en_q <= 1'b0;
                            hold_q    <= HW'(1);
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        turn_q <= turn_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign grant   = grant_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign pull_en = pull_en_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_shared_net_arbiter.sv
// Directed bench for shared_net_arbiter across three parameter sets.
module tb_shared_net_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_a, req_b, req_c;
    logic [3:0] grant_a, grant_b, grant_c;
    logic [1:0] owner_a, owner_b, owner_c;
    logic       busy_a, busy_b, busy_c;
    logic       pull_a, pull_b, pull_c;
    logic       tmo_a, tmo_b, tmo_c;

    int n_checks;
    int n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    shared_net_arbiter #(.N_REQ(4), .MAX_HOLD(16), .TURN_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .grant(grant_a), .owner(owner_a),
        .busy(busy_a), .pull_en(pull_a), .timeout(tmo_a)
    );

    shared_net_arbiter #(.N_REQ(4), .MAX_HOLD(4), .TURN_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .grant(grant_b), .owner(owner_b),
        .busy(busy_b), .pull_en(pull_b), .timeout(tmo_b)
    );

    shared_net_arbiter #(.N_REQ(4), .MAX_HOLD(0), .TURN_CYCLES(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req_c), .grant(grant_c), .owner(owner_c),
        .busy(busy_c), .pull_en(pull_c), .timeout(tmo_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        req_c = '0;
        step();
        step();

        // Reset state
        check_eq("rst_grant", 32'(grant_a), 32'h0);
        check_eq("rst_owner", 32'(owner_a), 32'h0);
        check_eq("rst_busy", 32'(busy_a), 32'h0);
        check_eq("rst_pull", 32'(pull_a), 32'h1);
        check_eq("rst_tmo", 32'(tmo_a), 32'h0);
        check_eq("rst_grant_c", 32'(grant_c), 32'h0);

        // Single request: held for 5 sampled edges, then dropped
        rst_n = 1'b1;
        req_a = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("single_grant", 32'(grant_a), 32'h1);
            check_eq("single_busy", 32'(busy_a), 32'h1);
            check_eq("single_pull", 32'(pull_a), 32'h0);
        end
        req_a = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            step();
            check_eq("single_rel_grant", 32'(grant_a), 32'h0);
            check_eq("single_rel_pull", 32'(pull_a), 32'h1);
            check_eq("single_rel_busy", 32'(busy_a), 32'h0);
        end

        // Contention and rotation: 0,1,2,3,0 with 4-cycle grants and 1-cycle gaps
        req_b = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 4; k++) begin
                step();
                check_eq("rot_grant", 32'(grant_b), 32'(4'b0001 << (g % 4)));
                check_eq("rot_owner", 32'(owner_b), 32'(g % 4));
                check_eq("rot_tmo_low", 32'(tmo_b), 32'h0);
            end
            if (g < 4) begin
                step();
                check_eq("rot_gap_grant", 32'(grant_b), 32'h0);
                check_eq("rot_gap_pull", 32'(pull_b), 32'h1);
                check_eq("rot_gap_tmo", 32'(tmo_b), 32'h1);
            end
        end
        req_b = 4'b0000;
        step();
        check_eq("rot_end_grant", 32'(grant_b), 32'h0);
        check_eq("rot_end_tmo", 32'(tmo_b), 32'h0);
        step();

        // Release vs. expiry collision on requester 1 (pointer is now 1)
        req_b = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("coll_grant", 32'(grant_b), 32'h2);
        end
        req_b = 4'b0000;
        step();
        check_eq("coll_tmo", 32'(tmo_b), 32'h0);
        check_eq("coll_grant_off", 32'(grant_b), 32'h0);
        check_eq("coll_pull", 32'(pull_b), 32'h1);
        step();
        check_eq("coll_tmo_after", 32'(tmo_b), 32'h0);

        // Sole hog on requester 2 for 20 cycles
        req_b = 4'b0100;
        for (int k = 0; k < 20; k++) begin
            step();
            check_eq("hog_exclusive", 32'((grant_b != 4'b0) && pull_b), 32'h0);
            if ((k % 5) < 4) begin
                check_eq("hog_grant", 32'(grant_b), 32'h4);
                check_eq("hog_owner", 32'(owner_b), 32'h2);
                check_eq("hog_tmo_low", 32'(tmo_b), 32'h0);
            end else begin
                check_eq("hog_gap_grant", 32'(grant_b), 32'h0);
                check_eq("hog_gap_tmo", 32'(tmo_b), 32'h1);
            end
        end
        step();
        check_eq("hog_regrant", 32'(grant_b), 32'h4);

        // Reset mid-grant
        rst_n = 1'b0;
        step();
        check_eq("midrst_grant", 32'(grant_b), 32'h0);
        check_eq("midrst_pull", 32'(pull_b), 32'h1);
        check_eq("midrst_tmo", 32'(tmo_b), 32'h0);
        rst_n = 1'b1;
        req_b = 4'b0110;
        step();
        check_eq("midrst_winner", 32'(grant_b), 32'h2);
        check_eq("midrst_owner", 32'(owner_b), 32'h1);
        req_b = 4'b0000;

        // Unlimited hold, 3-cycle turnaround
        req_c = 4'b0011;
        for (int k = 0; k < 100; k++) begin
            step();
            check_eq("unl_grant", 32'(grant_c), 32'h1);
            check_eq("unl_tmo", 32'(tmo_c), 32'h0);
        end
        req_c = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("unl_gap_grant", 32'(grant_c), 32'h0);
            check_eq("unl_gap_pull", 32'(pull_c), 32'h1);
            check_eq("unl_gap_busy", 32'(busy_c), 32'h0);
        end
        step();
        check_eq("unl_next_grant", 32'(grant_c), 32'h2);
        check_eq("unl_next_owner", 32'(owner_c), 32'h1);
        req_c = 4'b0000;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
